// File: rtl/melody_recorder.sv
// Records piano key presses as 5-bit note codes (0 = rest, 8..14 = do..si), one per beat slot,
// into an internal buffer with a length-masked, registered read port.
module melody_recorder #(
    parameter int BEAT_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int DEPTH       = 400,
    parameter int AW          = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rec_start,
    input  logic          rec_stop,
    input  logic [6:0]    key,
    input  logic [AW-1:0] rd_addr,
    output logic [4:0]    rd_code,
    output logic [AW-1:0] length,
    output logic          recording,
    output logic          full,
    output logic [4:0]    cur_code,
    output logic [6:0]    led,
    output logic [1:0]    dbg_state_o
);

    localparam int SLOT = BEAT_CYCLES + GAP_CYCLES;
    localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);
    localparam logic [AW-1:0] DEPTH_L   = AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] length_q, length_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          full_q, full_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [6:0]    key_s1_q, key_s2_q;
    logic [4:0]    cur_code_q;
    logic [6:0]    led_q;
    logic [4:0]    rd_code_q;
    logic [4:0]    enc_code;
    logic [6:0]    enc_led;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [4:0]    mem_q [DEPTH];

    // Scan from the top so the lowest pressed key is the last (winning) assignment.
    always_comb begin
        enc_code = 5'd0;
        enc_led  = 7'd0;
        for (int i = 6; i >= 0; i--) begin
            if (key_s2_q[i]) begin
                enc_code = 5'(8 + i);
                enc_led  = 7'b1 << i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            cur_code_q <= '0;
            led_q      <= '0;
        end else begin
            key_s1_q   <= key;
            key_s2_q   <= key_s1_q;
            cur_code_q <= enc_code;
            led_q      <= enc_led;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            length_q <= '0;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
            slot_q   <= slot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        slot_d   = slot_q;
        we       = 1'b0;
        wr_addr  = wr_ptr_q;
        case (state_q)
            IDLE, DONE: begin
                if (rec_start && !rec_stop) begin
                    state_d  = ARMED;
                    length_d = '0;
                    wr_ptr_d = '0;
                    full_d   = 1'b0;
                end
            end
            ARMED: begin
                if (rec_stop) begin
                    state_d  = IDLE;
                    length_d = '0;
                end else if (cur_code_q != 5'd0) begin
                    // First non-rest note starts the melody; leading rests are dropped.
                    we       = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = AW'(1);
                    length_d = AW'(1);
                    slot_d   = '0;
                    state_d  = RECORD;
                    if (AW'(1) == DEPTH_L) begin
                        full_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RECORD: begin
                if (rec_stop) begin
                    state_d = DONE;
                end else begin
                    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
                    if (slot_q == SLOT_LAST && !full_q) begin
                        we       = 1'b1;
                        length_d = length_q + AW'(1);
                        if (length_q + AW'(1) == DEPTH_L) begin
                            full_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + AW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= cur_code_q;
        end
    end

    // Reads see the pre-edge length and contents, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_code_q <= '0;
        end else begin
            rd_code_q <= (rd_addr < length_q) ? mem_q[rd_addr] : 5'd0;
        end
    end

    assign rd_code     = rd_code_q;
    assign length      = length_q;
    assign recording   = (state_q == ARMED) || (state_q == RECORD);
    assign full        = full_q;
    assign cur_code    = cur_code_q;
    assign led         = led_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_melody_recorder.sv
// Directed bench for melody_recorder with a 10-cycle slot and a 4-entry buffer.
module tb_melody_recorder;

    localparam int AW = 3;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_RECORD = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rec_start = 1'b0;
    logic          rec_stop = 1'b0;
    logic [6:0]    key = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [4:0]    rd_code;
    logic [AW-1:0] length;
    logic          recording;
    logic          full;
    logic [4:0]    cur_code;
    logic [6:0]    led;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] key;
        logic [4:0] code;
        logic [6:0] led;
    } enc_vec_t;

    enc_vec_t    enc_vecs[6];
    logic [AW-1:0] rb_addr[5];
    logic [4:0]    rb_exp[5];

    melody_recorder #(
        .BEAT_CYCLES(8),
        .GAP_CYCLES (2),
        .DEPTH      (4),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .key        (key),
        .rd_addr    (rd_addr),
        .rd_code    (rd_code),
        .length     (length),
        .recording  (recording),
        .full       (full),
        .cur_code   (cur_code),
        .led        (led),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        rec_start = 1'b1;
        tick(1);
        rec_start = 1'b0;
    endtask

    initial begin
        bit found;

        enc_vecs[0] = '{7'b0000100, 5'd10, 7'b0000100};
        enc_vecs[1] = '{7'b0100110, 5'd9,  7'b0000010};
        enc_vecs[2] = '{7'b1000000, 5'd14, 7'b1000000};
        enc_vecs[3] = '{7'b1111111, 5'd8,  7'b0000001};
        enc_vecs[4] = '{7'b0010000, 5'd12, 7'b0010000};
        enc_vecs[5] = '{7'b0000000, 5'd0,  7'b0000000};
        rb_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        rb_exp  = '{5'd8, 5'd8, 5'd0, 5'd0, 5'd0};

        // Reset values
        tick(2);
        check("rst_length", length, 0);
        check("rst_recording", recording, 0);
        check("rst_full", full, 0);
        check("rst_rd_code", rd_code, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        tick(1);

        // Start and stop together in IDLE: stop wins
        rec_start = 1'b1;
        rec_stop  = 1'b1;
        tick(1);
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        tick(1);
        check("both_idle_state", dbg_state, S_IDLE);
        check("both_idle_recording", recording, 0);

        // Encoder table, 3-cycle latency from key change
        for (int v = 0; v < 6; v++) begin
            key = enc_vecs[v].key;
            tick(3);
            check($sformatf("enc_code[%0d]", v), cur_code, enc_vecs[v].code);
            check($sformatf("enc_led[%0d]", v), led, enc_vecs[v].led);
        end

        // Arm, leading rests, first note, slot cadence
        pulse_start();
        check("arm_state", dbg_state, S_ARMED);
        check("arm_recording", recording, 1);
        tick(20);
        check("arm_rest_len", length, 0);
        check("arm_rest_state", dbg_state, S_ARMED);
        key = 7'b0000001;
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            tick(1);
            if (cur_code == 5'd8) found = 1'b1;
        end
        check("first_note_code", cur_code, 8);
        check("first_note_len_before", length, 0);
        tick(1);
        check("first_note_len", length, 1);
        check("first_note_state", dbg_state, S_RECORD);
        tick(9);
        check("slot1_len_early", length, 1);
        tick(1);
        check("slot1_len", length, 2);
        key = 7'b0000000;
        tick(9);
        check("slot2_len_early", length, 2);
        tick(1);
        check("slot2_len", length, 3);
        rec_stop = 1'b1;
        tick(1);
        rec_stop = 1'b0;
        check("stop_recording", recording, 0);
        check("stop_len", length, 3);
        check("stop_state", dbg_state, S_DONE);

        // Readback on consecutive cycles
        for (int a = 0; a < 5; a++) begin
            rd_addr = rb_addr[a];
            tick(1);
            check($sformatf("readback[%0d]", rb_addr[a]), rd_code, rb_exp[a]);
        end

        // Fill the buffer with si
        key = 7'b1000000;
        tick(3);
        check("si_code", cur_code, 14);
        pulse_start();
        check("full_arm_state", dbg_state, S_ARMED);
        tick(1);
        check("full_len1", length, 1);
        for (int k = 2; k <= 4; k++) begin
            tick(9);
            check($sformatf("full_len_early%0d", k), length, k - 1);
            check($sformatf("full_flag_early%0d", k), full, 0);
            tick(1);
            check($sformatf("full_len%0d", k), length, k);
        end
        check("full_flag", full, 1);
        check("full_state", dbg_state, S_DONE);
        tick(50);
        check("full_hold_len", length, 4);
        check("full_hold_flag", full, 1);
        check("full_hold_state", dbg_state, S_DONE);
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            tick(1);
            check($sformatf("full_read[%0d]", a), rd_code, 14);
        end

        // Rearm: length cleared masks old data, read-before-write at buf[0]
        rd_addr = 3'd0;
        pulse_start();
        check("rearm_state", dbg_state, S_ARMED);
        check("rearm_len", length, 0);
        check("rearm_full", full, 0);
        tick(1);
        check("rearm_rbw_read", rd_code, 0);
        check("rearm_len1", length, 1);
        tick(1);
        check("rearm_read_new", rd_code, 14);

        // Stop on the slot-end cycle: nothing written
        tick(8);
        rec_stop = 1'b1;
        tick(1);
        rec_stop = 1'b0;
        check("stop_slot_end_len", length, 1);
        check("stop_slot_end_state", dbg_state, S_DONE);

        // rec_start during RECORD is ignored
        pulse_start();
        tick(1);
        check("ign_len1", length, 1);
        tick(3);
        pulse_start();
        tick(5);
        check("ign_len_early", length, 1);
        tick(1);
        check("ign_len2", length, 2);
        check("ign_state", dbg_state, S_RECORD);
        check("ign_read", rd_code, 14);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_len", length, 0);
        check("async_rd_code", rd_code, 0);
        check("async_recording", recording, 0);
        check("async_full", full, 0);
        check("async_cur_code", cur_code, 0);
        check("async_led", led, 0);
        check("async_state", dbg_state, S_IDLE);
        tick(1);
        rst_n = 1'b1;
        rd_addr = 3'd0;
        tick(1);
        check("post_rst_read", rd_code, 0);
        check("post_rst_state", dbg_state, S_IDLE);
        check("post_rst_len", length, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
